// File: rtl/mdu_pkg.sv
// Shared types and widths for the multiply/divide unit controller.
// Holds the request opcode enum, the controller state enum and the datapath width.
// The MADD/MADDU/MSUB/MSUBU encodings always exist. Without MDU_MADD_EN the controller decodes them as NONE.
package mdu_pkg;

  localparam int MDU_W = 32;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: res = neg ? -val : val.
// Combinational, zero latency, no backpressure.
// Ports: val (W bits), neg (negate select), res (W bits).
// Used with neg=sign bit to form a magnitude. With that use, 0x80..0 maps to itself as an unsigned value.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide controller. It sequences an external unsigned multiplier and an external divider.
// Latency: MTHI/MTLO write at the accept edge. MULT writes 2 cycles after accept. DIV writes on the div_done cycle.
// Backpressure: busy stalls the execute stage while an op is in flight. req_valid/req_op/opA/opB must stay stable while busy.
// Ports:
//   clk, resetn (synchronous, active-low); req_valid, req_op, opA, opB, flush from execute.
//   busy, hi, lo to the pipeline.
//   mul_en, mul_a, mul_b, mul_p to the multiplier. mul_p is valid the cycle after mul_en.
//   div_start, div_abort, div_a, div_b, div_done, div_q, div_r to the divider.
// Build option: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU, which accumulate into {hi,lo}.
module mdu_ctrl
  import mdu_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  input  mdu_op_t            req_op,
  input  logic [MDU_W-1:0]   opA,
  input  logic [MDU_W-1:0]   opB,
  input  logic               flush,
  output logic               busy,
  output logic [MDU_W-1:0]   hi,
  output logic [MDU_W-1:0]   lo,
  output logic               mul_en,
  output logic [MDU_W-1:0]   mul_a,
  output logic [MDU_W-1:0]   mul_b,
  input  logic [2*MDU_W-1:0] mul_p,
  output logic               div_start,
  output logic               div_abort,
  output logic [MDU_W-1:0]   div_a,
  output logic [MDU_W-1:0]   div_b,
  input  logic               div_done,
  input  logic [MDU_W-1:0]   div_q,
  input  logic [MDU_W-1:0]   div_r
);

  mdu_state_t         state_q, state_d;
  logic [MDU_W-1:0]   hi_q, lo_q, hi_d, lo_d;
  logic               neg_q, qneg_q, rneg_q;

  logic               is_mul, is_div, is_mthi, is_mtlo, op_signed;
  logic               b_zero, accept;
  logic [MDU_W-1:0]   mag_a, mag_b, quot, rem;
  logic [2*MDU_W-1:0] prod, mul_res;

  // ---- request decode ----
`ifdef MDU_MADD_EN
  logic is_acc, is_sub, acc_q, sub_q;
  assign is_acc    = (req_op == OP_MADD) || (req_op == OP_MADDU) ||
                     (req_op == OP_MSUB) || (req_op == OP_MSUBU);
  assign is_sub    = (req_op == OP_MSUB) || (req_op == OP_MSUBU);
  assign is_mul    = (req_op == OP_MULT) || (req_op == OP_MULTU) || is_acc;
  assign op_signed = (req_op == OP_MULT) || (req_op == OP_DIV) ||
                     (req_op == OP_MADD) || (req_op == OP_MSUB);
`else
  assign is_mul    = (req_op == OP_MULT) || (req_op == OP_MULTU);
  assign op_signed = (req_op == OP_MULT) || (req_op == OP_DIV);
`endif
  assign is_div  = (req_op == OP_DIV) || (req_op == OP_DIVU);
  assign is_mthi = (req_op == OP_MTHI);
  assign is_mtlo = (req_op == OP_MTLO);
  assign b_zero  = (opB == '0);
  // A flush in the same cycle kills the incoming request as well.
  assign accept  = (state_q == ST_IDLE) && req_valid && !flush;

  // ---- sign handling: operand magnitudes and result correction ----
  mdu_sign_fix #(.W(MDU_W)) u_mag_a (.val(opA), .neg(op_signed & opA[MDU_W-1]), .res(mag_a));
  mdu_sign_fix #(.W(MDU_W)) u_mag_b (.val(opB), .neg(op_signed & opB[MDU_W-1]), .res(mag_b));
  mdu_sign_fix #(.W(2*MDU_W)) u_prod (.val(mul_p), .neg(neg_q),  .res(prod));
  mdu_sign_fix #(.W(MDU_W))   u_quot (.val(div_q), .neg(qneg_q), .res(quot));
  mdu_sign_fix #(.W(MDU_W))   u_rem  (.val(div_r), .neg(rneg_q), .res(rem));

  assign mul_a = mag_a;
  assign mul_b = mag_b;
  assign div_a = mag_a;
  assign div_b = mag_b;
  assign hi    = hi_q;
  assign lo    = lo_q;

`ifdef MDU_MADD_EN
  assign mul_res = !acc_q ? prod :
                   sub_q  ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`else
  assign mul_res = prod;
`endif

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mul)                state_d = ST_MUL;
        else if (accept && is_div && !b_zero) state_d = ST_DIV;
      end
      ST_MUL:  state_d = ST_IDLE;
      ST_DIV:  if (flush || div_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs and HI/LO next value ----
  // All strobes are gated by resetn so that they read as idle on every reset cycle.
  always_comb begin
    mul_en    = 1'b0;
    div_start = 1'b0;
    div_abort = 1'b0;
    busy      = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (resetn) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_mthi) hi_d = opA;
            if (is_mtlo) lo_d = opA;
            if (is_mul) begin
              mul_en = 1'b1;
              busy   = 1'b1;
            end
            // A divide by zero is dropped and leaves HI/LO unchanged.
            if (is_div && !b_zero) begin
              div_start = 1'b1;
              busy      = 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (!flush) {hi_d, lo_d} = mul_res;
        end
        ST_DIV: begin
          // flush wins over a coinciding div_done.
          if (flush) begin
            div_abort = 1'b1;
          end else if (div_done) begin
            lo_d = quot;
            hi_d = rem;
          end else begin
            busy = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- datapath registers ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q  <= 1'b0;
      sub_q  <= 1'b0;
`endif
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (mul_en) begin
        neg_q <= op_signed & (opA[MDU_W-1] ^ opB[MDU_W-1]);
`ifdef MDU_MADD_EN
        acc_q <= is_acc;
        sub_q <= is_sub;
`endif
      end
      if (div_start) begin
        qneg_q <= op_signed & (opA[MDU_W-1] ^ opB[MDU_W-1]);
        rneg_q <= op_signed & opA[MDU_W-1];
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl. Reference model uses 64-bit signed/unsigned arithmetic on HI/LO.
module tb_mdu_ctrl;
  import mdu_pkg::*;

`ifdef MDU_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  mdu_op_t     req_op;
  logic [31:0] opA, opB;
  logic        flush;
  logic        busy;
  logic [31:0] hi, lo;
  logic        mul_en;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_p;
  logic        div_start, div_abort;
  logic [31:0] div_a, div_b;
  logic        div_done;
  logic [31:0] div_q, div_r;

  int n_chk = 0;
  int n_err = 0;
  int op_id = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
    .opA(opA), .opB(opB), .flush(flush), .busy(busy), .hi(hi), .lo(lo),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .div_start(div_start), .div_abort(div_abort), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request and plays the multiplier/divider. Entered and left just after a rising edge.
  // flush_at: cycle index (0 = request cycle) in which flush is raised, -1 for none.
  task automatic do_op(input mdu_op_t op, input logic vld, input logic [31:0] a,
                       input logic [31:0] b, input int dlat, input int flush_at);
    bit sgn, is_mul, is_div, is_mt, killed, fin, fin_now;
    longint sa, sb, prod, q, r, ma, mb;
    logic [63:0] acc, res, pend;
    logic [31:0] dq, dr;
    int natural, c, start_c, nb, nm, ns, na, nx;
    string id;

    op_id++;
    id = $sformatf("op%0d", op_id);

    // ---- reference model ----
    sgn    = op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    is_mul = vld && (op inside {OP_MULT, OP_MULTU} ||
                     (MADD_ON && op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU}));
    is_div = vld && (op inside {OP_DIV, OP_DIVU}) && (b != 0);
    is_mt  = vld && (op inside {OP_MTHI, OP_MTLO});
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    natural = is_mul ? 1 : (is_div ? dlat + 1 : 0);
    killed  = (flush_at >= 0) && (flush_at <= natural);

    // ---- drive and run ----
    req_valid = vld; req_op = op; opA = a; opB = b;
    flush = (flush_at == 0); div_done = 1'b0;
    c = 0; start_c = -1; nb = 0; nm = 0; ns = 0; na = 0; nx = 0;
    pend = '0; dq = '0; dr = '0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (busy) nb++;
      if (mul_en) begin
        nm++;
        pend = {32'b0, mul_a} * {32'b0, mul_b};
        chk({id, " mul_a"}, {32'b0, mul_a}, ma);
        chk({id, " mul_b"}, {32'b0, mul_b}, mb);
      end
      if (div_start) begin
        ns++;
        start_c = c;
        chk({id, " div_a"}, {32'b0, div_a}, ma);
        chk({id, " div_b"}, {32'b0, div_b}, mb);
        dq = (div_b != 0) ? div_a / div_b : '0;
        dr = (div_b != 0) ? div_a % div_b : '0;
      end
      if (div_abort) na++;
      if (int'(mul_en) + int'(div_start) + int'(div_abort) > 1) nx++;
      fin_now = !busy;
      @(posedge clk); #1;
      c++;
      mul_p    = pend;
      flush    = (flush_at == c);
      div_done = (start_c >= 0) && (c == start_c + dlat + 1);
      div_q    = dq;
      div_r    = dr;
      if (fin_now) fin = 1'b1;
      else if (c > 200) begin
        chk({id, " timeout"}, 64'd1, 64'd0);
        fin = 1'b1;
      end
    end
    req_valid = 1'b0; req_op = OP_NONE; flush = 1'b0; div_done = 1'b0;

    // ---- architectural effect ----
    if (!killed) begin
      if (vld && op == OP_MTHI) m_hi = a;
      if (vld && op == OP_MTLO) m_lo = a;
      if (is_mul) begin
        prod = sa * sb;
        acc  = {m_hi, m_lo};
        if (op inside {OP_MADD, OP_MADDU})      res = acc + 64'(prod);
        else if (op inside {OP_MSUB, OP_MSUBU}) res = acc - 64'(prod);
        else                                    res = 64'(prod);
        {m_hi, m_lo} = res;
      end
      if (is_div) begin
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
    end

    chk({id, " busy_cycles"}, 64'(nb), 64'(killed ? flush_at : natural));
    chk({id, " mul_en_cnt"},  64'(nm), 64'(is_mul && flush_at != 0));
    chk({id, " div_start_cnt"}, 64'(ns), 64'(is_div && flush_at != 0));
    chk({id, " div_abort_cnt"}, 64'(na), 64'(is_div && killed && flush_at >= 1));
    chk({id, " pulse_overlap"}, 64'(nx), 64'd0);
    chk({id, " hi"}, {32'b0, hi}, {32'b0, m_hi});
    chk({id, " lo"}, {32'b0, lo}, {32'b0, m_lo});
    if (is_mt && killed) chk({id, " mt_killed_no_busy"}, 64'(nb), 64'd0);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  mdu_op_t ops [11] = '{OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI,
                        OP_MTLO, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};

  initial begin
    mdu_op_t op;
    // ---- reset, with a request waiting that must be ignored ----
    resetn = 1'b0; req_valid = 1'b1; req_op = OP_MULT; opA = 32'd7; opB = 32'd9;
    flush = 1'b0; mul_p = '0; div_done = 1'b0; div_q = '0; div_r = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst busy", {63'b0, busy}, 64'd0);
      chk("rst mul_en", {63'b0, mul_en}, 64'd0);
      chk("rst div_start", {63'b0, div_start}, 64'd0);
      chk("rst div_abort", {63'b0, div_abort}, 64'd0);
      @(posedge clk); #1;
      chk("rst hi", {32'b0, hi}, 64'd0);
      chk("rst lo", {32'b0, lo}, 64'd0);
    end
    resetn = 1'b1; req_valid = 1'b0; req_op = OP_NONE;

    // ---- directed cases ----
    do_op(OP_MTHI,  1'b1, 32'h11, 32'h0, 1, -1);
    do_op(OP_MTLO,  1'b1, 32'h22, 32'h0, 1, -1);
    do_op(OP_DIVU,  1'b1, 32'h55, 32'h0, 1, -1);            // divide by zero
    do_op(OP_MULT,  1'b1, 32'hFFFF_FFFE, 32'd3, 1, -1);      // -2*3
    do_op(OP_DIV,   1'b1, 32'hFFFF_FFF9, 32'd2, 10, -1);     // -7/2, busy 11
    do_op(OP_DIV,   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 3, -1);
    do_op(OP_DIV,   1'b1, 32'd100, 32'd7, 4, 5);             // flush with div_done
    do_op(OP_MTHI,  1'b1, 32'h1234, 32'h0, 1, -1);
    do_op(OP_MULTU, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, -1);
    do_op(OP_MTHI,  1'b1, 32'h0, 32'h0, 1, -1);
    do_op(OP_MTLO,  1'b1, 32'h5, 32'h0, 1, -1);
    do_op(OP_MSUB,  1'b1, 32'd2, 32'd3, 1, -1);
    do_op(OP_MADDU, 1'b1, 32'hFFFF_FFFF, 32'd2, 1, -1);
    do_op(OP_MULT,  1'b1, 32'd9, 32'd9, 1, 0);               // flush in request cycle
    do_op(OP_MULT,  1'b1, 32'd9, 32'd9, 1, 1);               // flush in MUL
    do_op(OP_MTLO,  1'b1, 32'hDEAD, 32'h0, 1, 0);            // flush kills MTLO
    do_op(OP_MULT,  1'b0, 32'd9, 32'd9, 1, -1);              // not valid
    do_op(OP_NONE,  1'b1, 32'd9, 32'd9, 1, -1);
    do_op(OP_DIV,   1'b1, 32'hFFFF_FF00, 32'd7, 6, 2);       // flush mid-divide

    // ---- randomized ops ----
    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, 10)];
      do_op(op, ($urandom_range(0, 9) != 0), pick_val(), pick_val(),
            int'($urandom_range(1, 6)),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    // ---- reset in the middle of a divide ----
    do_op(OP_MTHI, 1'b1, 32'hAAAA_5555, 32'h0, 1, -1);
    req_valid = 1'b1; req_op = OP_DIV; opA = 32'd100; opB = 32'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst busy", {63'b0, busy}, 64'd0);
      chk("midrst div_start", {63'b0, div_start}, 64'd0);
      chk("midrst div_abort", {63'b0, div_abort}, 64'd0);
      @(posedge clk); #1;
      chk("midrst hi", {32'b0, hi}, 64'd0);
      chk("midrst lo", {32'b0, lo}, 64'd0);
    end
    resetn = 1'b1; req_valid = 1'b0; req_op = OP_NONE;
    m_hi = '0; m_lo = '0;
    do_op(OP_MULT, 1'b1, 32'd5, 32'hFFFF_FFFA, 1, -1);
    do_op(OP_DIVU, 1'b1, 32'd50, 32'd8, 2, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; resetn  in  1  reset, synchronous, active-low.
REQ-002 SHALL have: req_valid  in  1  request from execute stage, held stable while busy.
REQ-003 SHALL have: req_op  in  mdu_op_t  NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO (+MADD/MADDU/MSUB/MSUBU per REQ-024).
REQ-004 SHALL have: opA, opB  in  32 each  rs/rt operands.
REQ-005 SHALL have: flush  in  1  exception kill of in-flight op.
REQ-006 SHALL have: busy  out  1  pipeline stall request; hi, lo  out  32 each  architectural HI/LO.
REQ-007 SHALL have multiplier side: mul_en out 1; mul_a, mul_b out 32 each (unsigned magnitudes); mul_p in 64 (unsigned product, valid the cycle after mul_en).
REQ-008 SHALL have divider side: div_start out 1 (pulse); div_abort out 1 (pulse); div_a, div_b out 32 each (magnitudes); div_done in 1; div_q, div_r in 32 each.

Function
REQ-009 SHALL implement FSM IDLE, MUL, DIV; requests accepted only in IDLE with req_valid=1.
REQ-010 MTHI/MTLO in IDLE SHALL write hi/lo with opA at that clock edge; busy=0; FSM stays IDLE.
REQ-011 MULT/MULTU in IDLE SHALL assert mul_en one cycle with |opA|,|opB| (signed) or raw (unsigned), latch neg=signed&(opA[31]^opB[31]), go MUL; busy=1 that cycle.
REQ-012 In MUL SHALL write {hi,lo}=neg ? -mul_p : mul_p (64-bit two's complement), return IDLE, busy=0; total latency 2 cycles, busy high exactly 1 cycle.
REQ-013 DIV/DIVU with opB!=0 SHALL pulse div_start with magnitudes, latch qneg=signed&(opA[31]^opB[31]) and rneg=signed&opA[31], go DIV; busy=1.
REQ-014 In DIV SHALL hold busy=1 until div_done; on div_done SHALL write lo=qneg?-div_q:div_q, hi=rneg?-div_r:div_r, return IDLE, busy=0 that cycle.
REQ-015 DIV/DIVU with opB==0 SHALL leave hi/lo unchanged, not start divider, busy=0, stay IDLE.
REQ-016 Magnitude of 0x80000000 SHALL be 0x80000000 (unsigned); DIV 0x80000000/0xFFFFFFFF SHALL yield lo=0x80000000, hi=0.
REQ-017 flush in MUL or DIV SHALL return to IDLE next edge without writing hi/lo; in DIV SHALL pulse div_abort; flush has priority over div_done in the same cycle.
REQ-018 flush in IDLE SHALL suppress acceptance of any request that cycle (no hi/lo write, no start).
REQ-019 req_op NONE or req_valid=0 SHALL produce no action; requests while in MUL/DIV SHALL be ignored.
REQ-020 mul_en, div_start, div_abort SHALL be single-cycle pulses, never asserted together.

Reset
REQ-021 resetn=0 SHALL set FSM=IDLE, hi=0, lo=0, neg/qneg/rneg=0, busy=0, mul_en=0, div_start=0, div_abort=0.
REQ-022 Reset mid-operation SHALL discard the operation; div_abort is not required during reset (divider has own reset).
REQ-023 Mid-reset outputs SHALL hold reset values every cycle resetn=0.

Configuration
REQ-024 Macro MDU_MADD_EN defined: SHALL accept MADD/MADDU/MSUB/MSUBU as MULT-class, MUL-state write {hi,lo}={hi,lo} ± signed-corrected product (mod 2^64).
REQ-025 MDU_MADD_EN undefined: those encodings SHALL behave as NONE; no accumulator adder synthesized.

Structure
REQ-026 Package mdu_pkg SHALL hold mdu_op_t, mdu_state_t and MDU_W=32.
REQ-027 Sub-module mdu_sign_fix SHALL implement magnitude and conditional negate, instantiated for operands and results.

Verification
REQ-028 MULT opA=0xFFFFFFFE(-2), opB=3 -> busy 1 cycle, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-029 DIV opA=0xFFFFFFF9(-7), opB=2, div_done after 10 cycles with q=3,r=1 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, busy 11 cycles.
REQ-030 DIVU opB=0 with hi=0x11,lo=0x22 -> no div_start, busy=0, hi/lo unchanged.
REQ-031 DIV in flight, flush and div_done same cycle -> div_abort pulse, hi/lo unchanged, IDLE next cycle.
REQ-032 MTHI 0x1234 then MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 With MDU_MADD_EN, hi=0,lo=5 then MSUB 2*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF; without it, no change, busy=0.
